// File: rtl/raw_fetch_pkg.sv
// raw_fetch_pkg
//   Shared definitions for the raw pixel fetcher:
//   - calc_ppw / calc_nwords : pixels per RAM word and words per frame
//   - fetch_state_t          : frame sequencing FSM states
//   - lane_sel               : maps the unpack index to a pixel lane in a word
package raw_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    function automatic int calc_ppw(input int word_w, input int pix_w);
        return word_w / pix_w;
    endfunction

    function automatic int calc_nwords(input int h_res, input int v_res, input int ppw);
        return (h_res * v_res) / ppw;
    endfunction

    // idx counts pixels already taken from the word; the lane is the bit group
    // [lane*PIX_W +: PIX_W] that carries that pixel.
    function automatic int lane_sel(input int idx, input int ppw, input bit msb_first);
        return msb_first ? (ppw - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/raw_word_fifo.sv
// raw_word_fifo
//   Synchronous show-ahead FIFO holding RAM words while the unpacker is busy.
//   Ports:
//     clock, reset         : rising-edge clock, synchronous active-high reset
//     push, push_data      : write one word
//     pop                  : discard the head word
//     pop_data             : head word (valid while !empty)
//     count, full, empty   : occupancy status
module raw_word_fifo
    import raw_fetch_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              push,
    input  logic [WORD_W-1:0]                 push_data,
    input  logic                              pop,
    output logic [WORD_W-1:0]                 pop_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              full,
    output logic                              empty
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            assert (!(pop && empty));
        end
    end

    assign pop_data = mem[rd_ptr];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/raw_pixel_fetcher.sv
// raw_pixel_fetcher
//   Reads a frame of packed raw Bayer pixels from a synchronous RAM and streams
//   them one pixel per transfer with frame/line markers.
//   Ports:
//     clock, reset            : rising-edge clock, synchronous active-high reset
//     start, base_addr        : begin a frame at base_addr (accepted only when idle)
//     busy, frame_done        : frame in progress / one-cycle completion pulse
//     rd_en, rd_addr, rd_data : RAM read port, data returns RAM_LAT cycles later
//     pix_data, pix_valid,
//     pix_ready               : pixel stream, transfer on valid && ready
//     pix_sof, pix_eol,
//     pix_eof                 : first-of-frame, last-of-line, last-of-frame markers
//   Optional build macro RAW_FETCH_COORD_EN adds pix_x / pix_y coordinate outputs.
module raw_pixel_fetcher
    import raw_fetch_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 17,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int RAM_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
`ifdef RAW_FETCH_COORD_EN
    ,
    output logic [$clog2(H_RES)-1:0] pix_x,
    output logic [$clog2(V_RES)-1:0] pix_y
`endif
);

    localparam int PPW    = calc_ppw(WORD_W, PIX_W);
    localparam int NWORDS = calc_nwords(H_RES, V_RES, PPW);
    localparam int IDX_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int RCNT_W = $clog2(NWORDS + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int XW     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW     = (V_RES > 1) ? $clog2(V_RES) : 1;

    function automatic logic [PIX_W-1:0] pick(input logic [WORD_W-1:0] w, input int idx);
        return w[lane_sel(idx, PPW, MSB_FIRST != 0) * PIX_W +: PIX_W];
    endfunction

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [RCNT_W-1:0] rd_cnt_q;
    logic [RAM_LAT-1:0] vld_p;
    logic              cap_vld;
    logic              credit_ok;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  nxt_idx;
    logic              word_left;
    logic              word_avail, load, pix_load, take_word;
    logic [WORD_W-1:0] word_in;
    logic [PIX_W-1:0]  pix_next;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic              sof_next, eol_next, eof_next;

    // ---- frame sequencing and read issue -----------------------------------
    // Credit: every read in flight or word parked in the FIFO holds one slot,
    // so a returning word always finds room.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        frame_done = 1'b0;
        rd_en      = 1'b0;
        credit_ok  = (int'($countones(vld_p)) + int'(fifo_count)) < FIFO_DEPTH;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy  = 1'b1;
                rd_en = credit_ok;
                if (credit_ok && (rd_cnt_q == RCNT_W'(NWORDS - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pix_valid && pix_ready && pix_eof) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rd_cnt_q <= '0;
            vld_p    <= '0;
        end else begin
            state_q <= state_d;
            // Bit N is set when the RAM word requested N+1 cycles ago is on rd_data.
            vld_p   <= (vld_p << 1) | RAM_LAT'(rd_en);
            if ((state_q == IDLE) && start) begin
                addr_q   <= base_addr;
                rd_cnt_q <= '0;
            end else if (rd_en) begin
                addr_q   <= addr_q + ADDR_W'(1);
                rd_cnt_q <= rd_cnt_q + RCNT_W'(1);
            end
            assert (!(fifo_push && fifo_full));
        end
    end

    assign rd_addr = addr_q;
    assign cap_vld = vld_p[RAM_LAT-1];

    // ---- read return: word FIFO --------------------------------------------
    raw_word_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (rd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---- unpack and output register ----------------------------------------
    // A word arriving into an empty FIFO is handed straight to the unpacker so
    // the FIFO adds no latency; otherwise the FIFO head is used.
    always_comb begin
        word_avail = !fifo_empty || cap_vld;
        word_in    = fifo_empty ? rd_data : fifo_head;
        load       = !pix_valid || pix_ready;
        pix_load   = load && (word_left || word_avail);
        take_word  = load && !word_left && word_avail;
        fifo_pop   = take_word && !fifo_empty;
        fifo_push  = cap_vld && !(take_word && fifo_empty);
        pix_next   = word_left ? pick(word_q, int'(nxt_idx)) : pick(word_in, 0);
        sof_next   = (x_q == '0) && (y_q == '0);
        eol_next   = (x_q == XW'(H_RES - 1));
        eof_next   = eol_next && (y_q == YW'(V_RES - 1));
    end

    always_ff @(posedge clock) begin
        if (take_word) begin
            word_q <= word_in;
        end
    end

    // x_q / y_q are the coordinates of the next pixel to be loaded, so the
    // markers registered alongside pix_data describe that pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
            nxt_idx   <= '0;
            word_left <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
`ifdef RAW_FETCH_COORD_EN
            pix_x     <= '0;
            pix_y     <= '0;
`endif
        end else if (load) begin
            pix_valid <= pix_load;
            pix_sof   <= pix_load && sof_next;
            pix_eol   <= pix_load && eol_next;
            pix_eof   <= pix_load && eof_next;
            if (pix_load) begin
                pix_data <= pix_next;
`ifdef RAW_FETCH_COORD_EN
                pix_x    <= x_q;
                pix_y    <= y_q;
`endif
                if (word_left) begin
                    nxt_idx   <= nxt_idx + IDX_W'(1);
                    word_left <= (nxt_idx != IDX_W'(PPW - 1));
                end else begin
                    nxt_idx   <= IDX_W'(1);
                    word_left <= (PPW > 1);
                end
                if (eol_next) begin
                    x_q <= '0;
                    y_q <= eof_next ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_raw_pixel_fetcher.sv
// Testbench for raw_pixel_fetcher: two instances share control inputs.
//   A: 32-bit words, 8-bit pixels, RAM_LAT=1, LSB lane first.
//   B: 64-bit words, 16-bit pixels, RAM_LAT=3, MSB lane first.
// Both use an 8x2 frame (4 words). RAM word at address a holds lane k = 4*a+k.
module tb_raw_pixel_fetcher;
    localparam int AW = 17;
    localparam int HR = 8;
    localparam int VR = 2;
    localparam int NPIX = HR * VR;

    logic          clock = 1'b0;
    logic          reset, start, pix_ready;
    logic [AW-1:0] base_addr;

    logic          a_busy, a_done, a_rd_en, a_valid, a_sof, a_eol, a_eof;
    logic [AW-1:0] a_rd_addr;
    logic [31:0]   a_rd_data;
    logic [7:0]    a_pix;
    logic          b_busy, b_done, b_rd_en, b_valid, b_sof, b_eol, b_eof;
    logic [AW-1:0] b_rd_addr;
    logic [63:0]   b_rd_data;
    logic [15:0]   b_pix;
`ifdef RAW_FETCH_COORD_EN
    logic [2:0] a_x, b_x;
    logic       a_y, b_y;
`endif

    always #5 clock = ~clock;

    raw_pixel_fetcher #(.WORD_W(32), .PIX_W(8), .ADDR_W(AW), .H_RES(HR), .V_RES(VR),
                        .RAM_LAT(1), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_a (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(a_busy), .frame_done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .pix_data(a_pix), .pix_valid(a_valid), .pix_ready(pix_ready),
        .pix_sof(a_sof), .pix_eol(a_eol), .pix_eof(a_eof)
`ifdef RAW_FETCH_COORD_EN
        , .pix_x(a_x), .pix_y(a_y)
`endif
    );

    raw_pixel_fetcher #(.WORD_W(64), .PIX_W(16), .ADDR_W(AW), .H_RES(HR), .V_RES(VR),
                        .RAM_LAT(3), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut_b (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(b_busy), .frame_done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .pix_data(b_pix), .pix_valid(b_valid), .pix_ready(pix_ready),
        .pix_sof(b_sof), .pix_eol(b_eol), .pix_eof(b_eof)
`ifdef RAW_FETCH_COORD_EN
        , .pix_x(b_x), .pix_y(b_y)
`endif
    );

    // RAM models
    function automatic logic [31:0] a_word(input logic [AW-1:0] a);
        logic [31:0] w;
        int unsigned v;
        for (int k = 0; k < 4; k++) begin
            v = 4 * int'(a) + k;
            w[8*k +: 8] = v[7:0];
        end
        return w;
    endfunction

    function automatic logic [63:0] b_word(input logic [AW-1:0] a);
        logic [63:0] w;
        int unsigned v;
        for (int k = 0; k < 4; k++) begin
            v = 4 * int'(a) + k;
            w[16*k +: 16] = v[15:0];
        end
        return w;
    endfunction

    logic [31:0] a_ram;
    logic [63:0] b_pipe [3];
    always @(posedge clock) begin
        a_ram     <= a_word(a_rd_addr);
        b_pipe[0] <= b_word(b_rd_addr);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_rd_data = a_ram;
    assign b_rd_data = b_pipe[2];

    // Scoreboard
    typedef struct packed {
        logic [15:0] d;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t          qa[$], qb[$];
    logic [AW-1:0] qa_addr[$], qb_addr[$];
    int tests = 0, fails = 0;
    int cyc = 0;
    int a_hs = 0;
    int a_eof_cyc = -100, b_eof_cyc = -100;
    bit a_stall = 0;
    logic [7:0] a_prev;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic push_frame(input logic [AW-1:0] base);
        exp_t ea, eb;
        logic [AW-1:0] ad;
        int unsigned v;
        for (int n = 0; n < NPIX; n++) begin
            ad = base + AW'(n / 4);
            v = 4 * int'(ad) + (n % 4);
            ea.d = {8'h00, v[7:0]};
            v = 4 * int'(ad) + (3 - n % 4);
            eb.d = v[15:0];
            ea.sof = (n == 0);
            ea.eol = (n % HR == HR - 1);
            ea.eof = (n == NPIX - 1);
            eb.sof = ea.sof;
            eb.eol = ea.eol;
            eb.eof = ea.eof;
            qa.push_back(ea);
            qb.push_back(eb);
        end
        for (int w = 0; w < NPIX / 4; w++) begin
            qa_addr.push_back(base + AW'(w));
            qb_addr.push_back(base + AW'(w));
        end
    endtask

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        if (a_rd_en) begin
            if (qa_addr.size() == 0) fail_now("a_rd_extra");
            else check("a_rd_addr", a_rd_addr, qa_addr.pop_front());
        end
        if (b_rd_en) begin
            if (qb_addr.size() == 0) fail_now("b_rd_extra");
            else check("b_rd_addr", b_rd_addr, qb_addr.pop_front());
        end
        if (a_stall) check("a_hold", {a_valid, a_pix}, {1'b1, a_prev});
        if (a_valid && pix_ready) begin
            a_hs++;
            if (a_eof) a_eof_cyc = cyc;
            if (qa.size() == 0) fail_now("a_pix_extra");
            else begin
                e = qa.pop_front();
                check("a_pix", {8'h00, a_pix}, e.d);
                check("a_markers", {a_sof, a_eol, a_eof}, {e.sof, e.eol, e.eof});
            end
        end
        if (b_valid && pix_ready) begin
            if (b_eof) b_eof_cyc = cyc;
            if (qb.size() == 0) fail_now("b_pix_extra");
            else begin
                e = qb.pop_front();
                check("b_pix", b_pix, e.d);
                check("b_markers", {b_sof, b_eol, b_eof}, {e.sof, e.eol, e.eof});
            end
        end
        a_stall = a_valid && !pix_ready;
        a_prev  = a_pix;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_a_ctl"}, {a_busy, a_done, a_rd_en, a_valid, a_sof, a_eol, a_eof}, 0);
        check({tag, "_a_addr_pix"}, {a_rd_addr, a_pix}, 0);
        check({tag, "_b_ctl"}, {b_busy, b_done, b_rd_en, b_valid, b_sof, b_eol, b_eof}, 0);
        check({tag, "_b_addr_pix"}, {b_rd_addr, b_pix}, 0);
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input bit rnd, input bit extra);
        int sc, a_first, b_first, a_dc, b_dc;
        push_frame(base);
        a_first = -1; b_first = -1; a_dc = 0; b_dc = 0;
        @(posedge clock); #1;
        base_addr = base; start = 1'b1; sc = cyc;
        @(posedge clock); #1;
        start = 1'b0; base_addr = 17'h00055;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (a_valid && a_first < 0) a_first = cyc;
            if (b_valid && b_first < 0) b_first = cyc;
            if (a_done) begin
                a_dc++;
                check("a_done_after_eof", cyc, a_eof_cyc + 1);
                check("a_busy_in_done", a_busy, 0);
                if (extra) start = 1'b1;
            end
            if (b_done) begin
                b_dc++;
                check("b_done_after_eof", cyc, b_eof_cyc + 1);
                check("b_busy_in_done", b_busy, 0);
            end
            if (a_dc > 0 && b_dc > 0) break;
            @(posedge clock); #1;
            start = (extra && i == 3) ? 1'b1 : 1'b0;
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (a_dc == 0 || b_dc == 0) fail_now("frame_timeout");
        @(posedge clock); #1;
        start = 1'b0; pix_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (a_done) a_dc++;
            if (b_done) b_dc++;
            check("idle_after_done", {a_busy, b_busy, a_rd_en, b_rd_en}, 0);
        end
        check("a_latency", a_first - sc, 3);
        check("b_latency", b_first - sc, 5);
        check("done_pulse_count", {a_dc[7:0], b_dc[7:0]}, {8'd1, 8'd1});
        check("queues_empty", {qa.size(), qb.size(), qa_addr.size(), qb_addr.size()}, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; pix_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // Frame from base 0 with ready held high
        run_frame(17'h00000, 1'b0, 1'b0);

        // Address wrap at the top of RAM with random backpressure
        run_frame(17'h1FFFE, 1'b1, 1'b0);

        // Reset mid-frame, then a fresh frame must start clean
        push_frame(17'h00010);
        a_hs = 0;
        @(posedge clock); #1;
        base_addr = 17'h00010; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 80 && a_hs < 5; i++) @(negedge clock);
        if (a_hs < 5) fail_now("midframe_timeout");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        qa.delete(); qb.delete(); qa_addr.delete(); qb_addr.delete();
        @(negedge clock);
        check_idle_outputs("midreset");
        run_frame(17'h00030, 1'b0, 1'b0);

        // Starts while busy and in the frame_done cycle are ignored
        run_frame(17'h00000, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/raw_pixel_fetcher.md
Name: raw_pixel_fetcher

Overview:
Frame-memory reader that streams raw Bayer pixels to the debayer stage. Issues sequential word reads to a synchronous frame RAM and absorbs the RAM read latency with a credit-controlled word FIFO. Unpacks each WORD_W word into PIX_W pixels and delivers them on a valid/ready stream with frame and line markers. Parametrised successor to the fixed 32-bit/8-bit, free-running unpacker: adds a frame start/stop protocol, backpressure, and a configurable pixel order.

Parameters:
WORD_W, 32, RAM word width; multiple of PIX_W
PIX_W, 8, raw pixel width
ADDR_W, 17, RAM word-address width
H_RES, 640, pixels per line; multiple of WORD_W/PIX_W
V_RES, 480, lines per frame
RAM_LAT, 1, RAM read latency in cycles (1..4)
FIFO_DEPTH, 4, word FIFO entries; must be >= RAM_LAT+1
MSB_FIRST, 0, 0 = lowest pixel lane output first; 1 = highest lane first

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a frame when idle
base_addr  in  ADDR_W  first word address; latched on an accepted start
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last pixel handshake
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM word address
rd_data  in  WORD_W  RAM data, valid RAM_LAT cycles after rd_en
pix_data  out  PIX_W  pixel
pix_valid  out  1  pixel valid
pix_ready  in  1  downstream ready; a transfer occurs when valid and ready are both high
pix_sof  out  1  qualifies the first pixel of the frame
pix_eol  out  1  qualifies the last pixel of each line
pix_eof  out  1  qualifies the last pixel of the frame

Behaviour:
- Reset: busy, frame_done, rd_en, pix_valid, pix_sof, pix_eol and pix_eof are 0; rd_addr is 0; pix_data is 0. The FIFO, credit count and all counters are cleared. The FSM enters IDLE. Reset mid-frame abandons the frame immediately; any in-flight read data is discarded.
- PPW = WORD_W/PIX_W. NWORDS = H_RES*V_RES/PPW.
- FSM states:
  - IDLE: start=1 latches base_addr, sets busy and goes to FETCH. start is ignored in every other state.
  - FETCH: assert rd_en whenever (in-flight reads + FIFO occupancy) < FIFO_DEPTH. rd_addr increments by 1 per read, modulo 2^ADDR_W. After NWORDS reads, go to DRAIN.
  - DRAIN: no reads. When the pix_eof handshake occurs, go to DONE.
  - DONE: frame_done=1 and busy=0 for one cycle, then return to IDLE.
- rd_data is captured into the FIFO exactly RAM_LAT cycles after its rd_en, using a RAM_LAT-deep valid shift register. The credit rule guarantees the FIFO never overflows. No write is dropped.
- Unpacker:
  - Holds one word and a lane index 0..PPW-1.
  - Presents lane (MSB_FIRST ? PPW-1-idx : idx), i.e. bits [lane*PIX_W +: PIX_W].
  - Advances on handshake. After the last lane it pops the next word in the same cycle, so there are no bubbles if the FIFO is non-empty.
- pix_data and pix_valid are registered. They hold stable while valid=1 and ready=0.
- Latency: with pix_ready=1, the first pix_valid occurs exactly RAM_LAT+2 cycles after the start cycle. Sustained throughput is 1 pixel per cycle.
- Counters x (0..H_RES-1) and y (0..V_RES-1) advance on handshake. x wraps to 0 and increments y.
  - pix_sof = (x==0 && y==0).
  - pix_eol = (x==H_RES-1).
  - pix_eof = pix_eol && (y==V_RES-1).
- Empty FIFO during FETCH: pix_valid drops; this is legal.
- pix_ready held low: reads stall once credits run out, and there is no data loss.
- A start pulse in the same cycle as frame_done is ignored. A new frame requires start while in IDLE.

Optional Feature:
RAW_FETCH_COORD_EN:
- Defined: adds outputs pix_x (width $clog2(H_RES)) and pix_y (width $clog2(V_RES)). These carry the current x/y, are aligned with pix_data, and reset to 0. Debayer uses them for Bayer-phase selection.
- Undefined: these ports and the extra output registers are absent. Markers are still produced.

Decomposition:
- Package raw_fetch_pkg: the PPW and NWORDS localparam functions, the FSM state enum (IDLE, FETCH, DRAIN, DONE), and the lane-select function.
- One sub-module: raw_word_fifo, a synchronous FIFO parametrised by WORD_W and FIFO_DEPTH, with count output, push/pop, and full/empty.

Test Plan:
1. Defaults, RAM words 0x03020100, 0x07060504, ..., base 0, ready=1 -> pixels 0x00,0x01,0x02,... First valid 3 cycles after start; 307200 pixels; sof on the first pixel; eol every 640 pixels; eof plus frame_done 1 cycle after.
2. MSB_FIRST=1, same memory -> pixel order 0x03,0x02,0x01,0x00,0x07,...
3. Random pix_ready (50%), RAM_LAT=3, FIFO_DEPTH=4 -> pixel sequence identical to test 1; no FIFO overflow assertion fires; in-flight + occupancy never exceeds 4.
4. WORD_W=64, PIX_W=16, H_RES=8, V_RES=2, base 0x1FFFE (ADDR_W=17) -> 4 reads with rd_addr 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; 16 pixels; eol at pixels 8 and 16.
5. reset asserted at pixel 100, then start -> all outputs 0 the next cycle; the new frame's first pixel is word[base][0]; no stale data.
6. start pulsed while busy and in the cycle of frame_done -> ignored; busy stays 0 after DONE until the next start.
